// File: rtl/noise_table_loader.sv
// rtl/noise_table_loader.sv - streams a blue-noise table into BRAM and verifies its 16-bit checksum trailer
module noise_table_loader #(
    parameter int ABITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             wr_en,
    output logic [ABITS-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             table_valid,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CSUM_LO,
        S_CSUM_HI,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ABITS-1:0] LAST_ADDR = '1;

    state_t           state, state_next;
    logic [ABITS-1:0] cnt;
    logic [15:0]      sum;
    logic [7:0]       csum_lo;

    logic             hs;
    logic             do_write;
    logic             do_clear;
    logic             latch_lo;
    logic             set_err;
    logic             set_valid;
    logic [1:0]       code_next;

    assign busy    = (state == S_LOAD) || (state == S_CSUM_LO) || (state == S_CSUM_HI);
    assign s_ready = busy;
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_clear   = 1'b0;
        latch_lo   = 1'b0;
        set_err    = 1'b0;
        set_valid  = 1'b0;
        code_next  = 2'd0;
        // abort outranks start and any same-cycle handshake; the offered byte is dropped
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_next = S_LOAD;
                        do_clear   = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        if (s_last) begin
                            state_next = S_ERROR;
                            set_err    = 1'b1;
                            code_next  = 2'd1;
                        end else begin
                            do_write = 1'b1;
                            if (cnt == LAST_ADDR) begin
                                state_next = S_CSUM_LO;
                            end
                        end
                    end
                end
                S_CSUM_LO: begin
                    if (hs) begin
                        if (s_last) begin
                            state_next = S_ERROR;
                            set_err    = 1'b1;
                            code_next  = 2'd1;
                        end else begin
                            latch_lo   = 1'b1;
                            state_next = S_CSUM_HI;
                        end
                    end
                end
                S_CSUM_HI: begin
                    if (hs) begin
                        if (!s_last) begin
                            state_next = S_ERROR;
                            set_err    = 1'b1;
                            code_next  = 2'd2;
                        end else if ({s_data, csum_lo} != sum) begin
                            state_next = S_ERROR;
                            set_err    = 1'b1;
                            code_next  = 2'd3;
                        end else begin
                            state_next = S_DONE;
                            set_valid  = 1'b1;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sum         <= '0;
            csum_lo     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            table_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            state <= state_next;
            wr_en <= do_write;
            if (do_clear) begin
                cnt         <= '0;
                sum         <= '0;
                err         <= 1'b0;
                err_code    <= 2'd0;
                table_valid <= 1'b0;
            end
            if (do_write) begin
                wr_addr <= cnt;
                wr_data <= s_data;
                sum     <= sum + {8'd0, s_data};
                // hold at the last address so the counter never wraps back to entry 0
                if (cnt != LAST_ADDR) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (latch_lo) begin
                csum_lo <= s_data;
            end
            if (set_err) begin
                err      <= 1'b1;
                err_code <= code_next;
            end
            if (set_valid) begin
                table_valid <= 1'b1;
            end
            if (abort) begin
                table_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noise_table_loader.sv
// tb/tb_noise_table_loader.sv - randomized scoreboard bench for noise_table_loader
module tb_noise_table_loader;

    localparam int ABITS = 12;
    localparam int DEPTH = 1 << ABITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             wr_en;
    logic [ABITS-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             busy;
    logic             table_valid;
    logic             err;
    logic [1:0]       err_code;

    noise_table_loader #(.ABITS(ABITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .table_valid (table_valid),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    logic [ABITS+7:0] wr_q[$];
    int               vectors = 0;
    int               miscompares = 0;

    // status request handed to the monitor: {s_ready, busy, table_valid, err, err_code}
    int               req_seq = 0;
    int               seen_seq = 0;
    logic [5:0]       exp_stat;
    bit               exp_wr_zero;
    string            stat_name;

    always @(negedge clk) begin
        if (wr_en) begin
            vectors++;
            if (wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
            end else begin
                logic [ABITS+7:0] exp_w;
                exp_w = wr_q.pop_front();
                if ({wr_addr, wr_data} !== exp_w) begin
                    miscompares++;
                    $display("FAIL write_seq: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             wr_addr, wr_data, exp_w[ABITS+7:8], exp_w[7:0]);
                end
            end
        end
        if (seen_seq != req_seq) begin
            vectors++;
            if ({s_ready, busy, table_valid, err, err_code} !== exp_stat) begin
                miscompares++;
                $display("FAIL %s status: got rdy/busy/tv/err/code=%b, expected %b",
                         stat_name, {s_ready, busy, table_valid, err, err_code}, exp_stat);
            end
            vectors++;
            if (wr_q.size() != 0) begin
                miscompares++;
                $display("FAIL %s writes_missing: got %0d outstanding, expected 0", stat_name, wr_q.size());
                wr_q.delete();
            end
            if (exp_wr_zero) begin
                vectors++;
                if ({wr_en, wr_addr, wr_data} !== '0) begin
                    miscompares++;
                    $display("FAIL %s wr_reset: got en=%b addr=%0h data=%0h, expected all 0",
                             stat_name, wr_en, wr_addr, wr_data);
                end
            end
            seen_seq = req_seq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string name, input logic [5:0] stat, input bit wr_zero);
        stat_name   = name;
        exp_stat    = stat;
        exp_wr_zero = wr_zero;
        req_seq++;
        for (int i = 0; i < 10 && seen_seq != req_seq; i++) tick();
        if (seen_seq != req_seq) begin
            $display("FAIL %s monitor_timeout: status not sampled", name);
            $fatal(1, "monitor stalled");
        end
    endtask

    task automatic send(input logic [7:0] d, input bit last, input int gap_pct);
        while ($urandom_range(99) < gap_pct) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // cut_mode: 0 = s_last on byte cut_at, 1 = abort with handshake, 2 = rst with handshake
    task automatic load_stream(input int gap_pct, input bit rnd, input int cut_at, input int cut_mode,
                               input int start_at, input logic [15:0] csum_xor, input bit hi_last);
        logic [15:0] sum = 16'd0;
        logic [7:0]  d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            if (i == start_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (i == cut_at) begin
                if (cut_mode == 0) begin
                    send(d, 1'b1, gap_pct);
                end else begin
                    s_valid = 1'b1;
                    s_data  = d;
                    if (cut_mode == 1) abort = 1'b1;
                    else rst = 1'b1;
                    tick();
                    s_valid = 1'b0;
                    abort   = 1'b0;
                    rst     = 1'b0;
                end
                return;
            end
            wr_q.push_back({ABITS'(i), d});
            sum = sum + 16'(d);
            send(d, 1'b0, gap_pct);
        end
        sum = sum ^ csum_xor;
        send(sum[7:0], 1'b0, gap_pct);
        send(sum[15:8], hi_last, gap_pct);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_status("reset", 6'b00_0_0_00, 1'b1);

        load_stream(0, 1'b0, -1, 0, -1, 16'h0000, 1'b1);
        tick();
        check_status("full_load", 6'b00_1_0_00, 1'b0);

        load_stream(30, 1'b0, -1, 0, -1, 16'h0000, 1'b1);
        tick();
        check_status("gapped_load", 6'b00_1_0_00, 1'b0);

        load_stream(10, 1'b0, 100, 0, -1, 16'h0000, 1'b1);
        tick();
        check_status("early_last", 6'b00_0_1_01, 1'b0);

        load_stream(0, 1'b0, -1, 0, -1, 16'h0F00, 1'b1);
        tick();
        check_status("bad_checksum", 6'b00_0_1_11, 1'b0);

        load_stream(15, 1'b0, -1, 0, -1, 16'h0000, 1'b0);
        tick();
        check_status("missing_last", 6'b00_0_1_10, 1'b0);

        load_stream(20, 1'b1, -1, 0, -1, 16'h0000, 1'b1);
        tick();
        check_status("random_load", 6'b00_1_0_00, 1'b0);

        load_stream(20, 1'b1, -1, 0, -1, 16'(1 + $urandom_range(16'hFFFE)), 1'b1);
        tick();
        check_status("random_bad_sum", 6'b00_0_1_11, 1'b0);

        load_stream(0, 1'b1, -1, 0, -1, 16'h0000, 1'b1);
        tick();
        load_stream(5, 1'b0, 2000, 1, -1, 16'h0000, 1'b1);
        tick();
        check_status("abort", 6'b00_0_0_00, 1'b0);

        load_stream(10, 1'b0, -1, 0, 700, 16'h0000, 1'b1);
        tick();
        check_status("reload_after_abort", 6'b00_1_0_00, 1'b0);

        load_stream(0, 1'b0, 1500, 2, -1, 16'h0000, 1'b1);
        check_status("mid_load_reset", 6'b00_0_0_00, 1'b1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
